// File: rtl/grid_draw_pkg.sv
// Shared constants for the grid renderer: pipe codes, colours, grid geometry
// and the frame-draw FSM encoding.
package grid_draw_pkg;

  localparam int TILE      = 8;
  localparam int GRID_N    = 6;
  localparam int INV_TILE  = GRID_N * GRID_N;

  localparam logic [2:0] EMPTY      = 3'd0;
  localparam logic [2:0] STRAIGHT_H = 3'd1;
  localparam logic [2:0] STRAIGHT_V = 3'd2;
  localparam logic [2:0] CORNER_UR  = 3'd3;
  localparam logic [2:0] CORNER_RD  = 3'd4;
  localparam logic [2:0] CORNER_DL  = 3'd5;

  localparam logic [2:0] BG        = 3'b000;
  localparam logic [2:0] CURSOR_BG = 3'b001;
  localparam logic [2:0] PIPE      = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/grid_draw_tile_pattern.sv
// Combinational 8x8 pipe glyph: decides whether pixel (px,py) of a tile
// showing pipe 'code' is lit.
import grid_draw_pkg::*;

module tile_pattern (
  input  logic [2:0] code,
  input  logic [2:0] px,
  input  logic [2:0] py,
  output logic       lit
);

  logic up, dn, lf, rt, mid_x, mid_y;

  always_comb begin
    up = 1'b0;
    dn = 1'b0;
    lf = 1'b0;
    rt = 1'b0;
    case (code)
      STRAIGHT_H: begin lf = 1'b1; rt = 1'b1; end
      STRAIGHT_V: begin up = 1'b1; dn = 1'b1; end
      CORNER_UR:  begin up = 1'b1; rt = 1'b1; end
      CORNER_RD:  begin rt = 1'b1; dn = 1'b1; end
      CORNER_DL:  begin dn = 1'b1; lf = 1'b1; end
      default:    ;
    endcase
    mid_x = (px == 3'd3) || (px == 3'd4);
    mid_y = (py == 3'd3) || (py == 3'd4);
    // Any connected pipe also lights the 2x2 centre.
    lit = (up && mid_x && (py <= 3'd2)) ||
          (dn && mid_x && (py >= 3'd5)) ||
          (lf && mid_y && (px <= 3'd2)) ||
          (rt && mid_y && (px >= 3'd5)) ||
          ((up | dn | lf | rt) && mid_x && mid_y);
  end

endmodule

// File: rtl/grid_draw.sv
// Frame renderer: on start, snapshots the grid and walks 36 grid tiles plus
// the inventory tile, emitting one VGA plot per cycle.
import grid_draw_pkg::*;

module grid_draw #(
  parameter int X0    = 56,
  parameter int Y0    = 36,
  parameter int INV_X = 112,
  parameter int INV_Y = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] r0,
  input  logic [17:0] r1,
  input  logic [17:0] r2,
  input  logic [17:0] r3,
  input  logic [17:0] r4,
  input  logic [17:0] r5,
  input  logic [3:0]  cur_x,
  input  logic [3:0]  cur_y,
  input  logic [2:0]  inv_pipe,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot
);

  state_t      state_q, state_d;
  logic [5:0]  tile_q, tile_d;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;

  logic [17:0] rows_q [GRID_N];
  logic [17:0] rows_d [GRID_N];
  logic [3:0]  cx_q, cx_d, cy_q, cy_d;
  logic [2:0]  inv_q, inv_d;

  logic        accept, inv_sel, hl, lit;
  logic [17:0] rsel;
  logic [4:0]  bit_idx;
  logic [2:0]  code, px, py;

  assign accept = (state_q == IDLE) && start;

  // Counters always point at the pixel presented on the outputs next cycle,
  // so the first pixel appears the cycle right after start is accepted.
  always_comb begin
    rows_d[0] = accept ? r0 : rows_q[0];
    rows_d[1] = accept ? r1 : rows_q[1];
    rows_d[2] = accept ? r2 : rows_q[2];
    rows_d[3] = accept ? r3 : rows_q[3];
    rows_d[4] = accept ? r4 : rows_q[4];
    rows_d[5] = accept ? r5 : rows_q[5];
    cx_d      = accept ? cur_x    : cx_q;
    cy_d      = accept ? cur_y    : cy_q;
    inv_d     = accept ? inv_pipe : inv_q;

    state_d = state_q;
    tile_d  = tile_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        tile_d = '0;
        row_d  = '0;
        col_d  = '0;
        cnt_d  = '0;
        if (start) state_d = DRAW;
      end
      DRAW: begin
        if (tile_q == 6'(INV_TILE) && cnt_q == 6'd63) begin
          state_d = DONE;
          tile_d  = '0;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            tile_d = tile_q + 6'd1;
            if (col_q == 3'(GRID_N - 1)) begin
              col_d = '0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    px      = cnt_d[2:0];
    py      = cnt_d[5:3];
    inv_sel = (tile_d == 6'(INV_TILE));
    case (row_d)
      3'd0:    rsel = rows_d[0];
      3'd1:    rsel = rows_d[1];
      3'd2:    rsel = rows_d[2];
      3'd3:    rsel = rows_d[3];
      3'd4:    rsel = rows_d[4];
      default: rsel = rows_d[5];
    endcase
    bit_idx = {2'b00, col_d} * 5'd3;
    code    = inv_sel ? inv_d : rsel[bit_idx +: 3];
    // Out-of-range cursor coordinates never match a column/row below 6.
    hl      = !inv_sel && (cx_d < 4'd6) && (cy_d < 4'd6) &&
              (cx_d == {1'b0, col_d}) && (cy_d == {1'b0, row_d});
  end

  tile_pattern u_pattern (
    .code (code),
    .px   (px),
    .py   (py),
    .lit  (lit)
  );

  always_comb begin
    busy_d   = (state_d == DRAW);
    done_d   = (state_d == DONE);
    plot_d   = busy_d;
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    if (busy_d) begin
      colour_d = lit ? PIPE : (hl ? CURSOR_BG : BG);
      if (inv_sel) begin
        x_d = 8'(INV_X) + {5'b0, px};
        y_d = 7'(INV_Y) + {4'b0, py};
      end else begin
        x_d = 8'(X0) + {2'b0, col_d, 3'b000} + {5'b0, px};
        y_d = 7'(Y0) + {1'b0, row_d, 3'b000} + {4'b0, py};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  always_ff @(posedge clk) begin
    rows_q <= rows_d;
    cx_q   <= cx_d;
    cy_q   <= cy_d;
    inv_q  <= inv_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;

endmodule

// File: tb/tb_grid_draw.sv
// Scoreboard bench for grid_draw: a reference model queues every expected
// pixel at start; a monitor pops and compares on each plot.
module tb_grid_draw;

  localparam int X0 = 56, Y0 = 36, INV_X = 112, INV_Y = 36;
  localparam int FRAME_PLOTS = 2368;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [17:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0;
  logic [3:0]  cur_x = '0, cur_y = '0;
  logic [2:0]  inv_pipe = '0;
  logic        busy, done, plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  grid_draw #(.X0(X0), .Y0(Y0), .INV_X(INV_X), .INV_Y(INV_Y)) dut (
    .clk(clk), .reset(reset), .start(start),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
    .cur_x(cur_x), .cur_y(cur_y), .inv_pipe(inv_pipe),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int          vectors = 0, miscompares = 0;
  logic [17:0] expq [$];
  logic [2:0]  fb [0:255][0:127];
  int          plot_cnt = 0, frames_done = 0, fd_mark = 0;
  logic        prev_plot = 1'b0;
  int          first_x, first_y, last_x, last_y;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_colour(input int code, input int px,
                                            input int py, input bit hl);
    bit u, d, l, r, mx, my, lit;
    u = 0; d = 0; l = 0; r = 0;
    case (code)
      1: begin l = 1; r = 1; end
      2: begin u = 1; d = 1; end
      3: begin u = 1; r = 1; end
      4: begin r = 1; d = 1; end
      5: begin d = 1; l = 1; end
      default: ;
    endcase
    mx  = (px == 3 || px == 4);
    my  = (py == 3 || py == 4);
    lit = (u && mx && py < 3) || (d && mx && py > 4) ||
          (l && my && px < 3) || (r && my && px > 4) ||
          ((u || d || l || r) && mx && my);
    return lit ? 3'b111 : (hl ? 3'b001 : 3'b000);
  endfunction

  task automatic push_frame();
    logic [17:0] rr [6];
    int row, col, px, py, code, x, y;
    bit hl;
    rr = '{r0, r1, r2, r3, r4, r5};
    for (int t = 0; t < 37; t++) begin
      for (int p = 0; p < 64; p++) begin
        px = p % 8;
        py = p / 8;
        if (t < 36) begin
          row  = t / 6;
          col  = t % 6;
          code = int'((rr[row] >> (3 * col)) & 18'd7);
          x    = X0 + 8 * col + px;
          y    = Y0 + 8 * row + py;
          hl   = (cur_x < 6) && (cur_y < 6) && (int'(cur_x) == col) && (int'(cur_y) == row);
        end else begin
          code = int'(inv_pipe);
          x    = INV_X + px;
          y    = INV_Y + py;
          hl   = 0;
        end
        expq.push_back({8'(x), 7'(y), ref_colour(code, px, py, hl)});
      end
    end
  endtask

  task automatic launch();
    push_frame();
    fd_mark = frames_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frames_done == fd_mark && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_seen", frames_done - fd_mark, 1);
    @(negedge clk);
  endtask

  task automatic set_inputs(input logic [17:0] a0, a1, a2, a3, a4, a5,
                            input logic [3:0] cx, cy, input logic [2:0] inv);
    r0 = a0; r1 = a1; r2 = a2; r3 = a3; r4 = a4; r5 = a5;
    cur_x = cx; cur_y = cy; inv_pipe = inv;
  endtask

  task automatic randomize_inputs(input bit random_cursor);
    set_inputs(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
               18'($urandom), 18'($urandom),
               random_cursor ? 4'($urandom_range(0, 7)) : cur_x,
               random_cursor ? 4'($urandom_range(0, 7)) : cur_y,
               3'($urandom_range(0, 7)));
  endtask

  // Monitor: scoreboard pop on plot, idle-output and done-pulse checks.
  always @(negedge clk) begin
    logic [17:0] e;
    if (reset) begin
      plot_cnt  = 0;
      prev_plot = 1'b0;
    end else begin
      if (plot) begin
        check("busy_in_draw", busy, 1);
        if (expq.size() == 0) begin
          check("unexpected_plot_x", vga_x, -1);
        end else begin
          e = expq.pop_front();
          check("pixel", {vga_x, vga_y, vga_colour}, e);
        end
        fb[vga_x][vga_y] = vga_colour;
        if (plot_cnt == 0) begin first_x = vga_x; first_y = vga_y; end
        last_x = vga_x;
        last_y = vga_y;
        plot_cnt++;
      end else begin
        check("idle_outputs", {busy, vga_x, vga_y, vga_colour}, 0);
        if (done) begin
          check("done_after_last_plot", prev_plot, 1);
          check("plots_per_frame", plot_cnt, FRAME_PLOTS);
          check("queue_drained", expq.size(), 0);
          frames_done++;
          plot_cnt = 0;
        end else if (prev_plot) begin
          check("done_pulse", done, 1);
        end
      end
      prev_plot = plot;
    end
  end

  initial begin
    int nz;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, plot, vga_x, vga_y, vga_colour}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty grid, cursor off-grid.
    set_inputs(0, 0, 0, 0, 0, 0, 4'd7, 4'd7, 3'd0);
    launch();
    wait_frame();
    check("first_pixel_x", first_x, 56);
    check("first_pixel_y", first_y, 36);
    check("last_pixel_x", last_x, 119);
    check("last_pixel_y", last_y, 43);

    // Horizontal pipe in cell (0,0) under the cursor.
    set_inputs(18'd1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 3'd0);
    launch();
    wait_frame();
    check("cell00_lit", fb[56][39], 3'b111);
    check("cell00_cursor_bg", fb[56][36], 3'b001);
    check("cell01_bg", fb[64][36], 3'b000);

    // Invalid code 7 in the last cell, vertical pipe in the inventory.
    set_inputs(0, 0, 0, 0, 0, 18'd7 << 15, 4'd7, 4'd7, 3'd2);
    launch();
    wait_frame();
    nz = 0;
    for (int x = 96; x < 104; x++)
      for (int y = 76; y < 84; y++)
        if (fb[x][y] != 3'b000) nz++;
    check("tile35_empty", nz, 0);
    check("inv_lit", fb[115][36], 3'b111);
    check("inv_unlit", fb[112][39], 3'b000);

    // Inputs and start disturbed mid-frame must not affect the draw.
    randomize_inputs(1);
    cur_x = 4'd2; cur_y = 4'd3;
    launch();
    repeat (499) @(negedge clk);
    randomize_inputs(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame();

    // A start right after done begins a new frame.
    randomize_inputs(1);
    launch();
    wait_frame();

    // Reset mid-frame abandons the draw asynchronously.
    randomize_inputs(1);
    launch();
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_plot_busy", {plot, busy}, 0);
    check("async_reset_outputs", {done, vga_x, vga_y, vga_colour}, 0);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    randomize_inputs(1);
    launch();
    wait_frame();
    check("post_reset_first_x", first_x, 56);
    check("post_reset_first_y", first_y, 36);

    for (int k = 0; k < 3; k++) begin
      randomize_inputs(1);
      launch();
      wait_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grid_draw.md
GRID_DRAW -- requirements
Module: grid_draw

Interface
REQ-001 SHALL have parameter X0, default 56, meaning the screen x of grid cell (0,0) top-left pixel.
REQ-002 SHALL have parameter Y0, default 36, meaning the screen y of grid cell (0,0) top-left pixel.
REQ-003 SHALL have parameter INV_X, default 112, meaning the screen x of the inventory tile.
REQ-004 SHALL have parameter INV_Y, default 36, meaning the screen y of the inventory tile.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  frame draw request; sampled only in IDLE.
REQ-008 r0..r5  in  18 each  grid rows; cell x occupies bits [3x+2:3x].
REQ-009 cur_x, cur_y  in  4 each  cursor cell.
REQ-010 inv_pipe  in  3  inventory pipe code.
REQ-011 busy  out  1  high while the frame is drawing.
REQ-012 done  out  1  one-cycle pulse at the end of a frame.
REQ-013 vga_x  out  8  plot x; vga_y  out  7  plot y; vga_colour  out  3  plot colour.
REQ-014 plot  out  1  pixel write enable for the VGA adapter.

Function
REQ-015 FSM SHALL have states IDLE, DRAW and DONE, with transitions IDLE->DRAW on start=1, DRAW->DONE after the last pixel, and DONE->IDLE unconditionally.
REQ-016 The start-accepting edge SHALL snapshot r0..r5, cur_x, cur_y and inv_pipe; the draw SHALL use only the snapshot, so input changes during DRAW have no effect.
REQ-017 DRAW SHALL emit 37 tiles of 8x8 pixels, one pixel per cycle with plot=1, for exactly 2368 consecutive cycles starting the cycle after start is accepted.
REQ-018 Tile order SHALL be index t = 0..35 for grid cell (row t/6, col t%6), then t = 36 for the inventory tile.
REQ-019 The 6-bit pixel counter SHALL map px=cnt[2:0] and py=cnt[5:3]; t SHALL increment when cnt wraps from 63 to 0.
REQ-020 Grid tile position SHALL be vga_x = X0+8*col+px and vga_y = Y0+8*row+py; the inventory tile SHALL be at INV_X+px, INV_Y+py.
REQ-021 Pipe arms (lit pixels) SHALL be: up = cols 3-4, rows 0-2; down = cols 3-4, rows 5-7; left = rows 3-4, cols 0-2; right = rows 3-4, cols 5-7; centre = rows 3-4, cols 3-4.
REQ-022 Codes SHALL draw as: 1 left+right, 2 up+down, 3 up+right, 4 right+down, 5 down+left, each with centre; codes 0, 6 and 7 SHALL draw empty.
REQ-023 Lit pixels SHALL be colour 3'b111.
REQ-024 Unlit pixels SHALL be colour 3'b001 in the cursor cell and 3'b000 elsewhere, including the inventory tile.
REQ-025 If the snapshot cur_x>5 or cur_y>5, no cell SHALL be highlighted.
REQ-026 busy SHALL be 1 exactly in DRAW.
REQ-027 done SHALL be 1 exactly in DONE, the cycle after the last plot.
REQ-028 start SHALL be ignored while in DRAW or DONE.
REQ-029 Outside DRAW, plot SHALL be 0 and vga_x, vga_y and vga_colour SHALL be 0.

Reset
REQ-030 reset SHALL force IDLE immediately, independent of clk, with busy=done=plot=0, vga_x=vga_y=vga_colour=0, and tile and pixel counters at 0.
REQ-031 Reset mid-frame SHALL abandon the frame; the next start SHALL draw a complete frame from tile 0.

Structure
REQ-032 A shared package SHALL hold the pipe code constants (EMPTY=0 through CORNER_DL=5), colour constants (BG, CURSOR_BG, PIPE), TILE=8, GRID_N=6 and the FSM state encoding.
REQ-033 A combinational sub-module tile_pattern (inputs code, px, py; output lit) SHALL implement REQ-021 and REQ-022.

Verification
REQ-034 All rows 0, cursor (7,7), start: 2368 plot cycles, all colour 000; first pixel (56,36); last pixel (119,43); done high the next cycle.
REQ-035 r0[2:0]=1, cursor (0,0): (56,39)=111, (56,36)=001, (64,36)=000.
REQ-036 r5[17:15]=7 and inv_pipe=2: tile 35 entirely 000; inventory (115,36)=111 and (112,39)=000.
REQ-037 Change r0..r5 and pulse start at cycle 500 of DRAW: output is unchanged versus the undisturbed frame and exactly 2368 plots occur; a start after done begins a new frame.
REQ-038 Assert reset at DRAW cycle 100: plot and busy drop to 0 without a clock edge; the next start yields a full 2368-plot frame beginning at (56,36).
